// File: rtl/jtsdram_check_if.sv
// Read-port bundle between the SDRAM read-back checker (master) and the SDRAM
// controller read port (slave).
interface jtsdram_check_if #(
    parameter int AW = 22
);
    logic [AW-1:0] rd_addr;
    logic [1:0]    rd_ba;
    logic          rd_req;
    logic          rd_ack;
    logic          rd_dok;
    logic [15:0]   rd_data;

    modport master (
        output rd_addr, rd_ba, rd_req,
        input  rd_ack, rd_dok, rd_data
    );

    modport slave (
        input  rd_addr, rd_ba, rd_req,
        output rd_ack, rd_dok, rd_data
    );
endinterface

// File: rtl/jtsdram_check.sv
// SDRAM read-back checker: reads every word of each enabled bank, compares it
// with the address-derived fill pattern and reports pass/fail plus first error.
//
//  state | meaning
//  IDLE  | waiting for start after reset
//  NEXT  | pick lowest enabled bank >= current, or finish
//  REQ   | rd_req held with stable bank/address until rd_ack
//  WAIT  | waiting for rd_dok, timeout down-counter running
//  CMP   | compare latched word, update error state, advance address
//  DONE  | result valid, held until next start
module jtsdram_check #(
    parameter int          AW    = 22,
    parameter logic [15:0] SEED  = 16'h5A3C,
    parameter int          ERR_W = 16,
    parameter int          TOUT  = 1023
) (
    input  logic               rst,
    input  logic               clk,
    input  logic               start,
    input  logic [3:0]         ba_en,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [1:0]         first_ba,
    output logic [AW-1:0]      first_addr,
    output logic [15:0]        first_data,
    jtsdram_check_if.master    rd
);
    localparam int TW = (TOUT > 0) ? $clog2(TOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, NEXT, REQ, WAIT, CMP, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       ba_q, ba_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [3:0]       en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [1:0]       first_ba_q, first_ba_d;
    logic [AW-1:0]    first_addr_q, first_addr_d;
    logic [15:0]      first_data_q, first_data_d;
    logic [15:0]      data_q, data_d;
    logic             tout_q, tout_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             rd_req_q, rd_req_d;

    logic             nxt_found;
    logic [2:0]       nxt_ba;
    logic             mism;

    // Address bits that fall outside a narrow AW read as zero, so the same
    // formula covers both the 22-bit device and small test configurations.
    function automatic logic [15:0] exp_word(input logic [1:0] ba, input logic [AW-1:0] addr);
        logic [15:0] lo16;
        logic [11:0] hi12;
        lo16 = 16'(addr);
        hi12 = 12'({addr, 12'd0} >> AW);
        return lo16 ^ {2'b00, ba, hi12} ^ SEED;
    endfunction

    always_comb begin
        nxt_found = 1'b0;
        nxt_ba    = ba_q;
        for (int i = 3; i >= 0; i--) begin
            if (en_q[i] && (3'(i) >= ba_q)) begin
                nxt_found = 1'b1;
                nxt_ba    = 3'(i);
            end
        end
    end

    assign mism = tout_q || (data_q != exp_word(ba_q[1:0], addr_q));

    always_comb begin
        state_d      = state_q;
        ba_d         = ba_q;
        addr_d       = addr_q;
        en_d         = en_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_cnt_d    = err_cnt_q;
        first_ba_d   = first_ba_q;
        first_addr_d = first_addr_q;
        first_data_d = first_data_q;
        data_d       = data_q;
        tout_d       = tout_q;
        tcnt_d       = tcnt_q;
        rd_req_d     = rd_req_q;

        case (state_q)
            NEXT: begin
                if (nxt_found) begin
                    ba_d     = nxt_ba;
                    rd_req_d = 1'b1;
                    state_d  = REQ;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_q == '0);
                    state_d = DONE;
                end
            end
            REQ: begin
                if (rd.rd_ack) begin
                    rd_req_d = 1'b0;
                    tout_d   = 1'b0;
                    tcnt_d   = TW'(TOUT);
                    if (rd.rd_dok) begin
                        data_d  = rd.rd_data;
                        state_d = CMP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (rd.rd_dok) begin
                    data_d  = rd.rd_data;
                    state_d = CMP;
                end else if (tcnt_q == '0) begin
                    data_d  = 16'hFFFF;
                    tout_d  = 1'b1;
                    state_d = CMP;
                end else begin
                    tcnt_d = tcnt_q - 1'b1;
                end
            end
            CMP: begin
                if (mism) begin
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                    if (err_cnt_q == '0) begin
                        first_ba_d   = ba_q[1:0];
                        first_addr_d = addr_q;
                        first_data_d = data_q;
                    end
                end
                // ba_q is one bit wider than a bank index so bank 3 wrapping
                // lands on 4, which NEXT treats as "no banks left".
                if (addr_q == '1) begin
                    addr_d  = '0;
                    ba_d    = ba_q + 3'd1;
                    state_d = NEXT;
                end else begin
                    addr_d   = addr_q + 1'b1;
                    rd_req_d = 1'b1;
                    state_d  = REQ;
                end
            end
            default: ;
        endcase

        if (start) begin
            state_d      = NEXT;
            busy_d       = 1'b1;
            done_d       = 1'b0;
            pass_d       = 1'b0;
            err_cnt_d    = '0;
            first_ba_d   = '0;
            first_addr_d = '0;
            first_data_d = '0;
            addr_d       = '0;
            ba_d         = '0;
            en_d         = ba_en;
            tout_d       = 1'b0;
            rd_req_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ba_q         <= '0;
            addr_q       <= '0;
            en_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            first_ba_q   <= '0;
            first_addr_q <= '0;
            first_data_q <= '0;
            data_q       <= '0;
            tout_q       <= 1'b0;
            tcnt_q       <= '0;
            rd_req_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ba_q         <= ba_d;
            addr_q       <= addr_d;
            en_q         <= en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_cnt_q    <= err_cnt_d;
            first_ba_q   <= first_ba_d;
            first_addr_q <= first_addr_d;
            first_data_q <= first_data_d;
            data_q       <= data_d;
            tout_q       <= tout_d;
            tcnt_q       <= tcnt_d;
            rd_req_q     <= rd_req_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_cnt_q;
    assign first_ba   = first_ba_q;
    assign first_addr = first_addr_q;
    assign first_data = first_data_q;
    assign rd.rd_req  = rd_req_q;
    assign rd.rd_ba   = ba_q[1:0];
    assign rd.rd_addr = addr_q;
endmodule

// File: tb/tb_jtsdram_check.sv
// Directed bench for jtsdram_check: an SDRAM read-port model checks the read
// order against a scoreboard queue, and each pass result is checked against fixed expectations.
module tb_jtsdram_check;
    localparam int          AW    = 4;
    localparam int          ERR_W = 3;
    localparam int          TOUT  = 8;
    localparam logic [15:0] SEED  = 16'h5A3C;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [3:0]       ba_en = 4'b0000;
    logic             busy, done, pass;
    logic [ERR_W-1:0] err_cnt;
    logic [1:0]       first_ba;
    logic [AW-1:0]    first_addr;
    logic [15:0]      first_data;

    jtsdram_check_if #(.AW(AW)) rd_if ();

    jtsdram_check #(.AW(AW), .SEED(SEED), .ERR_W(ERR_W), .TOUT(TOUT)) dut (
        .rst        (rst),
        .clk        (clk),
        .start      (start),
        .ba_en      (ba_en),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .first_ba   (first_ba),
        .first_addr (first_addr),
        .first_data (first_data),
        .rd         (rd_if.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // read-port model knobs
    int            lat = 2;
    bit            corrupt_en = 1'b0;
    logic [1:0]    corrupt_ba = '0;
    logic [AW-1:0] corrupt_addr = '0;
    bit            drop_en = 1'b0;
    logic [1:0]    drop_ba = '0;
    logic [AW-1:0] drop_addr = '0;
    bit            all_wrong = 1'b0;
    int            acks = 0;
    int            req_hi = 0;
    int            req_idle = 0;
    logic [5:0]    sb_q[$];

    function automatic logic [15:0] model_exp(input logic [1:0] ba, input logic [AW-1:0] addr);
        logic [15:0] a16;
        a16 = {12'd0, addr};
        return a16 ^ {2'b00, ba, 12'd0} ^ (a16 << 8) ^ SEED;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_run();
        bit          pend_valid;
        int          pend_cnt;
        logic [15:0] pend_data;
        logic [15:0] d;
        logic [5:0]  exp_ra;
        pend_valid = 1'b0;
        pend_cnt   = 0;
        pend_data  = '0;
        forever begin
            @(negedge clk);
            rd_if.rd_ack  = 1'b0;
            rd_if.rd_dok  = 1'b0;
            rd_if.rd_data = 16'h0000;
            if (rd_if.rd_req) req_hi++;
            if (rd_if.rd_req && !busy) req_idle++;
            if (pend_valid) begin
                if (pend_cnt == 0) begin
                    rd_if.rd_dok  = 1'b1;
                    rd_if.rd_data = pend_data;
                    pend_valid    = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (rd_if.rd_req) begin
                rd_if.rd_ack = 1'b1;
                acks++;
                chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    exp_ra = sb_q.pop_front();
                    chk("sb_rd_addr", 32'({rd_if.rd_ba, rd_if.rd_addr}), 32'(exp_ra));
                end
                d = model_exp(rd_if.rd_ba, rd_if.rd_addr);
                if (all_wrong) d = ~d;
                if (corrupt_en && rd_if.rd_ba == corrupt_ba && rd_if.rd_addr == corrupt_addr)
                    d = d ^ 16'h0001;
                if (!(drop_en && rd_if.rd_ba == drop_ba && rd_if.rd_addr == drop_addr)) begin
                    if (lat == 0) begin
                        rd_if.rd_dok  = 1'b1;
                        rd_if.rd_data = d;
                    end else begin
                        pend_valid = 1'b1;
                        pend_cnt   = lat - 1;
                        pend_data  = d;
                    end
                end
            end
        end
    endtask

    task automatic start_pass(input logic [3:0] en);
        logic [1:0]    b2;
        logic [AW-1:0] a4;
        @(negedge clk);
        sb_q.delete();
        for (int b = 0; b < 4; b++) begin
            if (en[b]) begin
                for (int a = 0; a < 16; a++) begin
                    b2 = 2'(b);
                    a4 = AW'(a);
                    sb_q.push_back({b2, a4});
                end
            end
        end
        req_hi   = 0;
        req_idle = 0;
        ba_en    = en;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", 32'(done), 32'd1);
    endtask

    initial begin
        int base;
        int n;
        fork
            model_run();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_req", 32'(rd_if.rd_req), 32'd0);
        chk("rst_fdata", 32'(first_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // empty mask finishes two cycles after start without any read
        start_pass(4'b0000);
        chk("empty_busy1", 32'(busy), 32'd1);
        chk("empty_done0", 32'(done), 32'd0);
        chk("empty_req0", 32'(rd_if.rd_req), 32'd0);
        @(negedge clk);
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_pass", 32'(pass), 32'd1);
        chk("empty_busy0", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("empty_noreq", 32'(req_hi), 32'd0);

        // clean single bank
        start_pass(4'b0001);
        chk("t1_req0", 32'(rd_if.rd_req), 32'd0);
        wait_done();
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_err", 32'(err_cnt), 32'd0);
        chk("t1_sb_left", 32'(sb_q.size()), 32'd0);
        chk("t1_req_idle", 32'(req_idle), 32'd0);

        // sparse mask with one flipped bit on bank 3
        corrupt_en = 1'b1; corrupt_ba = 2'd3; corrupt_addr = AW'(5);
        start_pass(4'b1010);
        wait_done();
        corrupt_en = 1'b0;
        chk("t2_err", 32'(err_cnt), 32'd1);
        chk("t2_fba", 32'(first_ba), 32'd3);
        chk("t2_faddr", 32'(first_addr), 32'd5);
        chk("t2_fdata", 32'(first_data), 32'h6F38);
        chk("t2_pass", 32'(pass), 32'd0);
        chk("t2_sb_left", 32'(sb_q.size()), 32'd0);

        // missing data on ba0 addr 2 times out
        drop_en = 1'b1; drop_ba = 2'd0; drop_addr = AW'(2);
        start_pass(4'b0001);
        wait_done();
        drop_en = 1'b0;
        chk("t3_err", 32'(err_cnt), 32'd1);
        chk("t3_fba", 32'(first_ba), 32'd0);
        chk("t3_faddr", 32'(first_addr), 32'd2);
        chk("t3_fdata", 32'(first_data), 32'hFFFF);
        chk("t3_pass", 32'(pass), 32'd0);
        chk("t3_sb_left", 32'(sb_q.size()), 32'd0);

        // every word wrong: counter saturates
        all_wrong = 1'b1;
        start_pass(4'b0001);
        wait_done();
        all_wrong = 1'b0;
        chk("t4_err_sat", 32'(err_cnt), 32'd7);
        chk("t4_faddr", 32'(first_addr), 32'd0);
        chk("t4_fdata", 32'(first_data), 32'hA5C3);
        chk("t4_pass", 32'(pass), 32'd0);

        // data returned in the ack cycle, error on the last word of the bank
        lat = 0;
        corrupt_en = 1'b1; corrupt_ba = 2'd2; corrupt_addr = AW'(15);
        start_pass(4'b0100);
        wait_done();
        corrupt_en = 1'b0;
        lat = 2;
        chk("t5_err", 32'(err_cnt), 32'd1);
        chk("t5_fba", 32'(first_ba), 32'd2);
        chk("t5_faddr", 32'(first_addr), 32'd15);
        chk("t5_fdata", 32'(first_data), 32'(model_exp(2'd2, AW'(15)) ^ 16'h0001));
        chk("t5_pass", 32'(pass), 32'd0);
        chk("t5_sb_left", 32'(sb_q.size()), 32'd0);

        // restart while a bad word is in flight; its late rd_dok must be dropped
        corrupt_en = 1'b1; corrupt_ba = 2'd0; corrupt_addr = AW'(3);
        base = acks;
        start_pass(4'b0001);
        n = 0;
        while ((acks - base) < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reached_ack", 32'((acks - base) >= 4), 32'd1);
        corrupt_en = 1'b0;
        start_pass(4'b0001);
        chk("t6_busy", 32'(busy), 32'd1);
        chk("t6_done0", 32'(done), 32'd0);
        chk("t6_req0", 32'(rd_if.rd_req), 32'd0);
        wait_done();
        chk("t6_pass", 32'(pass), 32'd1);
        chk("t6_err", 32'(err_cnt), 32'd0);
        chk("t6_sb_left", 32'(sb_q.size()), 32'd0);

        // reset in the middle of a pass
        corrupt_en = 1'b1; corrupt_ba = 2'd0; corrupt_addr = AW'(0);
        start_pass(4'b0011);
        repeat (10) @(negedge clk);
        corrupt_en = 1'b0;
        chk("t7_err_pre", 32'(err_cnt), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_req", 32'(rd_if.rd_req), 32'd0);
        chk("t7_err", 32'(err_cnt), 32'd0);
        chk("t7_done", 32'(done), 32'd0);
        rst = 1'b0;
        req_idle = 0;
        repeat (6) @(negedge clk);
        chk("t7_idle_busy", 32'(busy), 32'd0);
        chk("t7_idle_req", 32'(req_hi), 32'(req_hi - req_idle));

        start_pass(4'b0001);
        wait_done();
        chk("t8_pass", 32'(pass), 32'd1);
        chk("t8_sb_left", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
